// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit pipelined MIPS core: address width,
// reset vector and the fetch sequencer state encoding.
package core_pkg;

    localparam int unsigned ADDR_W   = 8;
    localparam logic [7:0]  RESET_PC = 8'h00;

    // Encoding is visible on state_o for debug, so the values are fixed.
    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        RUN   = 3'd1,
        STALL = 3'd2,
        FLUSH = 3'd3,
        HALT  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_next_pc.sv
// Next-address mux: redirect target when a redirect is taken, else pc+1.
// The increment wraps modulo 2^ADDR_W.
module fetch_sequencer_next_pc #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] next_pc
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Select redirect target or sequential successor.
    always_comb begin
        next_pc = redirect ? target : pc + ONE;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, chooses between sequential fetch, branch
// redirect, stall and halt, and produces a registered flush pulse train
// after each redirect. All outputs come straight from flops.
module fetch_sequencer #(
    parameter int unsigned          ADDR_W       = core_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0]    RESET_PC     = core_pkg::RESET_PC,
    parameter int unsigned          FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              halt_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    output logic              flush_o,
    output logic              halted_o,
    output logic [2:0]        state_o
);

    import core_pkg::*;

    localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [2:0]        cnt;
    logic [2:0]        cnt_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic              pc_load;
    logic              redirect;
    logic              valid_next;
    logic              flush_next;
    logic              halted_next;

    fetch_sequencer_next_pc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .pc       (pc),
        .redirect (redirect),
        .target   (branch_target_i),
        .next_pc  (next_pc)
    );

    // Next-state, PC update enable and next values of the registered outputs.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pc_load    = 1'b0;
        redirect   = 1'b0;
        unique case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (branch_taken_i) begin
                    redirect   = 1'b1;
                    pc_load    = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = FLUSH;
                end else if (halt_i) begin
                    state_next = HALT;
                end else if (stall_i) begin
                    state_next = STALL;
                end else begin
                    pc_load = 1'b1;
                end
            end
            STALL: begin
                if (branch_taken_i) begin
                    redirect   = 1'b1;
                    pc_load    = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = FLUSH;
                end else if (!stall_i) begin
                    pc_load    = 1'b1;
                    state_next = RUN;
                end
            end
            FLUSH: begin
                // Inputs here come from squashed instructions and are ignored.
                pc_load = 1'b1;
                if (cnt == 3'd0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
        valid_next  = (state_next == RUN) || (state_next == STALL) ||
                      (state_next == FLUSH);
        flush_next  = (state_next == FLUSH);
        halted_next = (state_next == HALT);
    end

    // State, PC, flush counter and output registers; reset aborts everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            cnt        <= '0;
            pc_valid_o <= 1'b0;
            flush_o    <= 1'b0;
            halted_o   <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            pc_valid_o <= valid_next;
            flush_o    <= flush_next;
            halted_o   <= halted_next;
            if (pc_load) begin
                pc <= next_pc;
            end
        end
    end

    assign pc_o    = pc;
    assign state_o = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: vector table, directed corner cases and a
// randomized run against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

    localparam int unsigned FC = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       stall_i = 1'b0;
    logic       branch_taken_i = 1'b0;
    logic [7:0] branch_target_i = 8'h00;
    logic       halt_i = 1'b0;
    logic [7:0] pc_o;
    logic       pc_valid_o;
    logic       flush_o;
    logic       halted_o;
    logic [2:0] state_o;

    fetch_sequencer #(
        .ADDR_W       (8),
        .RESET_PC     (8'h00),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .halt_i          (halt_i),
        .pc_o            (pc_o),
        .pc_valid_o      (pc_valid_o),
        .flush_o         (flush_o),
        .halted_o        (halted_o),
        .state_o         (state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: phase flags plus remaining flush cycles.
    logic [7:0] m_pc;
    bit         m_booted;
    bit         m_halted;
    bit         m_stalled;
    int         m_flush_left;

    typedef struct {
        logic       stall;
        logic       br;
        logic [7:0] tgt;
        logic       halt;
        logic [7:0] pc;
        logic       valid;
        logic       flush;
        logic [2:0] st;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] m_state();
        if (!m_booted)             return 3'd0;
        else if (m_halted)         return 3'd4;
        else if (m_flush_left > 0) return 3'd3;
        else if (m_stalled)        return 3'd2;
        else                       return 3'd1;
    endfunction

    task automatic model_reset();
        m_pc = 8'h00; m_booted = 0; m_halted = 0; m_stalled = 0; m_flush_left = 0;
    endtask

    task automatic model_step(input logic s, input logic b, input logic [7:0] t, input logic h);
        if (m_halted) begin
        end else if (!m_booted) begin
            m_booted = 1;
        end else if (m_flush_left > 0) begin
            m_pc = m_pc + 8'd1;
            m_flush_left--;
        end else if (b) begin
            m_pc = t;
            m_flush_left = FC;
            m_stalled = 0;
        end else if (h && !m_stalled) begin
            m_halted = 1;
        end else if (s) begin
            m_stalled = 1;
        end else begin
            m_pc = m_pc + 8'd1;
            m_stalled = 0;
        end
    endtask

    task automatic check_model();
        check("pc", pc_o, m_pc);
        check("pc_valid", {7'd0, pc_valid_o}, {7'd0, (m_booted && !m_halted)});
        check("flush", {7'd0, flush_o}, {7'd0, (m_flush_left > 0)});
        check("halted", {7'd0, halted_o}, {7'd0, m_halted});
        check("state", {5'd0, state_o}, {5'd0, m_state()});
    endtask

    // Called just after a falling edge: drive, clock, then compare at the next falling edge.
    task automatic cycle(input logic s, input logic b, input logic [7:0] t, input logic h);
        stall_i = s; branch_taken_i = b; branch_target_i = t; halt_i = h;
        @(posedge clk);
        model_step(s, b, t, h);
        @(negedge clk);
        check_model();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        model_reset();
        stall_i = 0; branch_taken_i = 0; halt_i = 0; branch_target_i = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("rst_pc", pc_o, 8'h00);
        check("rst_valid", {7'd0, pc_valid_o}, 8'd0);
        check("rst_flush", {7'd0, flush_o}, 8'd0);
        check("rst_halted", {7'd0, halted_o}, 8'd0);
        check("rst_state", {5'd0, state_o}, 8'd0);
        reset_n = 1'b1;
    endtask

    function automatic vec_t mk(logic s, logic b, logic [7:0] t, logic h,
                                logic [7:0] p, logic v, logic f, logic [2:0] st);
        vec_t r;
        r.stall = s; r.br = b; r.tgt = t; r.halt = h;
        r.pc = p; r.valid = v; r.flush = f; r.st = st;
        return r;
    endfunction

    initial begin
        vecs[0]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 3'd1);
        vecs[1]  = mk(0, 0, 8'h00, 0, 8'h01, 1, 0, 3'd1);
        vecs[2]  = mk(0, 0, 8'h00, 0, 8'h02, 1, 0, 3'd1);
        vecs[3]  = mk(0, 0, 8'h00, 0, 8'h03, 1, 0, 3'd1);
        vecs[4]  = mk(0, 0, 8'h00, 0, 8'h04, 1, 0, 3'd1);
        vecs[5]  = mk(0, 0, 8'h00, 0, 8'h05, 1, 0, 3'd1);
        vecs[6]  = mk(0, 1, 8'h40, 0, 8'h40, 1, 1, 3'd3);
        vecs[7]  = mk(0, 0, 8'h00, 0, 8'h41, 1, 1, 3'd3);
        vecs[8]  = mk(0, 0, 8'h00, 0, 8'h42, 1, 0, 3'd1);
        vecs[9]  = mk(0, 0, 8'h00, 0, 8'h43, 1, 0, 3'd1);
        vecs[10] = mk(1, 0, 8'h00, 0, 8'h43, 1, 0, 3'd2);
        vecs[11] = mk(1, 0, 8'h00, 0, 8'h43, 1, 0, 3'd2);
        vecs[12] = mk(1, 1, 8'h20, 0, 8'h20, 1, 1, 3'd3);
        vecs[13] = mk(0, 0, 8'h00, 1, 8'h21, 1, 1, 3'd3);
        vecs[14] = mk(0, 0, 8'h00, 0, 8'h22, 1, 0, 3'd1);
        vecs[15] = mk(0, 1, 8'h30, 1, 8'h30, 1, 1, 3'd3);
        vecs[16] = mk(0, 0, 8'h00, 0, 8'h31, 1, 1, 3'd3);
        vecs[17] = mk(0, 0, 8'h00, 0, 8'h32, 1, 0, 3'd1);

        @(negedge clk);
        apply_reset();

        for (int i = 0; i < 18; i++) begin
            cycle(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].halt);
            check($sformatf("vec%0d_pc", i), pc_o, vecs[i].pc);
            check($sformatf("vec%0d_valid", i), {7'd0, pc_valid_o}, {7'd0, vecs[i].valid});
            check($sformatf("vec%0d_flush", i), {7'd0, flush_o}, {7'd0, vecs[i].flush});
            check($sformatf("vec%0d_state", i), {5'd0, state_o}, {5'd0, vecs[i].st});
        end

        // Stall three cycles at pc=10, then release.
        cycle(0, 1, 8'h0E, 0);
        cycle(0, 0, 8'h00, 0);
        cycle(0, 0, 8'h00, 0);
        check("at_10", pc_o, 8'h10);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 8'h00, 0);
            check("stall_hold", pc_o, 8'h10);
        end
        cycle(0, 0, 8'h00, 0);
        check("stall_release", pc_o, 8'h11);

        // Branch to the current pc is a normal redirect.
        cycle(0, 1, 8'h11, 0);
        check("self_branch_pc", pc_o, 8'h11);
        check("self_branch_flush", {7'd0, flush_o}, 8'd1);
        cycle(0, 0, 8'h00, 0);
        cycle(0, 0, 8'h00, 0);

        // Wrap from FF to 00.
        cycle(0, 1, 8'hFD, 0);
        cycle(0, 0, 8'h00, 0);
        cycle(0, 0, 8'h00, 0);
        check("at_ff", pc_o, 8'hFF);
        cycle(0, 0, 8'h00, 0);
        check("wrap_pc", pc_o, 8'h00);
        check("wrap_valid", {7'd0, pc_valid_o}, 8'd1);

        // Halt freezes everything until reset.
        cycle(0, 0, 8'h00, 1);
        check("halt_valid", {7'd0, pc_valid_o}, 8'd0);
        check("halt_flag", {7'd0, halted_o}, 8'd1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
            check("halt_frozen", pc_o, 8'h00);
        end

        // Asynchronous reset in the middle of a flush.
        @(negedge clk);
        apply_reset();
        cycle(0, 0, 8'h00, 0);
        cycle(0, 1, 8'h50, 0);
        check("pre_rst_state", {5'd0, state_o}, 8'd3);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("async_pc", pc_o, 8'h00);
        check("async_flush", {7'd0, flush_o}, 8'd0);
        check("async_state", {5'd0, state_o}, 8'd0);
        check("async_valid", {7'd0, pc_valid_o}, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cycle(0, 0, 8'h00, 0);
        check("post_rst_pc", pc_o, 8'h00);

        // Randomized run against the model.
        begin
            int halt_cycles;
            halt_cycles = 0;
            for (int i = 0; i < 3000; i++) begin
                logic s, b, h;
                logic [7:0] t;
                s = ($urandom_range(0, 3) == 0);
                b = ($urandom_range(0, 7) == 0);
                h = ($urandom_range(0, 47) == 0);
                t = ($urandom_range(0, 3) == 0) ? m_pc : 8'($urandom);
                cycle(s, b, t, h);
                if (m_halted) halt_cycles++;
                if (halt_cycles > 5) begin
                    halt_cycles = 0;
                    @(negedge clk);
                    apply_reset();
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
